load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit_if.sv | 37 +++
 rtl/load_store_unit.sv | 184 ++++++++++++++++++
 tb/tb_load_store_unit.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// lsu_if : pipeline request/response and data-RAM bus of the load/store unit
// Rev 1.0
// ----------------------------------------------------------------------------
interface lsu_if #(
  parameter int ADDR_W = 12
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic [ADDR_W-1:0] data_memory_address;
  logic [31:0]       data_memory_data_in;
  logic              store;
  logic              load;
  logic [31:0]       data_memory_data_out;

  // Environment side: pipeline requester plus RAM read data.
  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, data_memory_data_out,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           data_memory_address, data_memory_data_in, store, load
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, data_memory_data_out,
    output req_ready, resp_valid, resp_rdata, resp_err,
           data_memory_address, data_memory_data_in, store, load
  );
endinterface
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// load_store_unit : RV32I byte/half/word load-store sequencer for a word RAM
// Optional macro LSU_RMW_EN enables SB/SH via read-modify-write.   Rev 1.0
// ----------------------------------------------------------------------------
module load_store_unit #(
  parameter int ADDR_W = 12
) (
  input  wire logic clk,
  input  wire logic rst_n,
  lsu_if.slave      bus
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RD_ISSUE = 3'd1,
    S_RD_DATA  = 3'd2,
    S_WR_ISSUE = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  state_t            r_state;
  logic [2:0]        r_funct3;
  logic [1:0]        r_lane;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_data_in;
  logic              r_load;
  logic              r_store;
  logic              r_resp_valid;
  logic              r_resp_err;
  logic [31:0]       r_resp_rdata;
`ifdef LSU_RMW_EN
  logic              r_we;
  logic [15:0]       r_wdata;
`endif

  logic [2:0]  w_f3;
  logic [1:0]  w_lo;
  logic        w_misalign;
  logic        w_illegal_load;
  logic        w_illegal_store;
  logic        w_err;
  logic        w_unused_addr_hi;
  logic [31:0] w_rd;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_ext;

  assign w_f3 = bus.req_funct3;
  assign w_lo = bus.req_addr[1:0];
  // Upper byte-address bits fall outside the RAM and simply wrap.
  assign w_unused_addr_hi = ^bus.req_addr[31:ADDR_W+2];

  assign w_misalign     = ((w_f3[1:0] == 2'b01) && w_lo[0]) ||
                          ((w_f3[1:0] == 2'b10) && (w_lo != 2'b00));
  assign w_illegal_load = (w_f3 == 3'b011) || (w_f3[2:1] == 2'b11);
`ifdef LSU_RMW_EN
  assign w_illegal_store = (w_f3 >= 3'b011);
`else
  assign w_illegal_store = (w_f3 != 3'b010);
`endif
  assign w_err = w_misalign || (bus.req_we ? w_illegal_store : w_illegal_load);

  assign w_rd   = bus.data_memory_data_out;
  assign w_half = r_lane[1] ? w_rd[31:16] : w_rd[15:0];

  always_comb begin
    w_byte = w_rd[7:0];
    case (r_lane)
      2'd1:    w_byte = w_rd[15:8];
      2'd2:    w_byte = w_rd[23:16];
      2'd3:    w_byte = w_rd[31:24];
      default: w_byte = w_rd[7:0];
    endcase
  end

  always_comb begin
    w_ext = w_rd;
    case (r_funct3)
      3'b000:  w_ext = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_ext = {{16{w_half[15]}}, w_half};
      3'b100:  w_ext = {24'd0, w_byte};
      3'b101:  w_ext = {16'd0, w_half};
      default: w_ext = w_rd;
    endcase
  end

`ifdef LSU_RMW_EN
  logic [31:0] w_merged;

  always_comb begin
    w_merged = w_rd;
    if (r_funct3[0] == 1'b0)
      w_merged[{r_lane, 3'b000} +: 8] = r_wdata[7:0];
    else
      w_merged[{r_lane[1], 4'b0000} +: 16] = r_wdata;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_funct3     <= 3'd0;
      r_lane       <= 2'd0;
      r_addr       <= '0;
      r_data_in    <= 32'd0;
      r_load       <= 1'b0;
      r_store      <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= 32'd0;
`ifdef LSU_RMW_EN
      r_we         <= 1'b0;
      r_wdata      <= 16'd0;
`endif
    end else begin
      r_load       <= 1'b0;
      r_store      <= 1'b0;
      r_resp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.req_valid) begin
            r_funct3 <= w_f3;
            r_lane   <= w_lo;
            r_addr   <= bus.req_addr[ADDR_W+1:2];
`ifdef LSU_RMW_EN
            r_we     <= bus.req_we;
            r_wdata  <= bus.req_wdata[15:0];
`endif
            if (w_err) begin
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b1;
              r_resp_rdata <= 32'd0;
              r_state      <= S_DONE;
            end else if (bus.req_we && (w_f3 == 3'b010)) begin
              r_data_in <= bus.req_wdata;
              r_store   <= 1'b1;
              r_state   <= S_WR_ISSUE;
            end else begin
              // Loads and sub-word stores both start with a RAM read.
              r_load  <= 1'b1;
              r_state <= S_RD_ISSUE;
            end
          end
        end
        S_RD_ISSUE: r_state <= S_RD_DATA;
        S_RD_DATA: begin
`ifdef LSU_RMW_EN
          if (r_we) begin
            r_data_in <= w_merged;
            r_store   <= 1'b1;
            r_state   <= S_WR_ISSUE;
          end else
`endif
          begin
            r_resp_valid <= 1'b1;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= w_ext;
            r_state      <= S_DONE;
          end
        end
        S_WR_ISSUE: begin
          r_resp_valid <= 1'b1;
          r_resp_err   <= 1'b0;
          r_resp_rdata <= 32'd0;
          r_state      <= S_DONE;
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready           = (r_state == S_IDLE);
  assign bus.resp_valid          = r_resp_valid;
  assign bus.resp_err            = r_resp_err;
  assign bus.resp_rdata          = r_resp_rdata;
  assign bus.data_memory_address = r_addr;
  assign bus.data_memory_data_in = r_data_in;
  assign bus.store               = r_store;
  assign bus.load                = r_load;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_load_store_unit : directed self-checking bench with a synchronous RAM model
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_load_store_unit;
  localparam int AW = 12;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lsu_if #(.ADDR_W(AW)) bus ();

  load_store_unit #(.ADDR_W(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [31:0] mem [0:4095];
  logic [31:0] rd_q;
  logic        pre_we = 1'b0;
  logic [11:0] pre_addr = 12'd0;
  logic [31:0] pre_data = 32'd0;

  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    if (bus.store) mem[bus.data_memory_address] <= bus.data_memory_data_in;
    if (bus.load) rd_q <= mem[bus.data_memory_address];
  end
  assign bus.data_memory_data_out = rd_q;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic preload(input logic [11:0] a, input logic [31:0] d);
    @(negedge clk);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(posedge clk);
    #1 pre_we = 1'b0;
  endtask

  // Issues one op and observes it until resp_valid (8-cycle bound).
  task automatic do_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, output int lat, output int nld, output int nst,
                       output int ld_cyc, output int st_cyc, output logic [11:0] mem_a,
                       output logic [31:0] din, output logic [31:0] rdata, output logic err,
                       output logic rdy_issue, output logic busy_ready);
    lat = 0; nld = 0; nst = 0; ld_cyc = 0; st_cyc = 0; mem_a = 12'd0;
    din = 32'd0; rdata = 32'd0; err = 1'b0; busy_ready = 1'b0;
    @(negedge clk);
    rdy_issue = bus.req_ready;
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_funct3 = f3;
    bus.req_addr = addr; bus.req_wdata = wd;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0; bus.req_we = ~we; bus.req_funct3 = 3'b111;
    bus.req_addr = 32'hFFFF_FFFF; bus.req_wdata = 32'h0BAD_F00D;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (bus.load)  begin nld++; ld_cyc = k; mem_a = bus.data_memory_address; end
      if (bus.store) begin nst++; st_cyc = k; mem_a = bus.data_memory_address;
                           din = bus.data_memory_data_in; end
      if (bus.resp_valid) begin lat = k; rdata = bus.resp_rdata; err = bus.resp_err; break; end
      if (bus.req_ready) busy_ready = 1'b1;
    end
  endtask

  int lat, nld, nst, ldc, stc;
  logic [11:0] ma;
  logic [31:0] din, rdata;
  logic err, rdy, brdy;

  task automatic test_reset;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'd0;
    bus.req_addr = 32'd0; bus.req_wdata = 32'd0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (bus.resp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_resp_valid: got %b want 0", bus.resp_valid); end
    n_cmp++; if (bus.resp_rdata !== 32'd0) begin n_fail++; $display("FAIL rst_resp_rdata: got %h want 0", bus.resp_rdata); end
    n_cmp++; if ({bus.load, bus.store, bus.resp_err} !== 3'b000) begin n_fail++; $display("FAIL rst_strobes: got %b want 000", {bus.load, bus.store, bus.resp_err}); end
    n_cmp++; if (bus.data_memory_address !== 12'd0) begin n_fail++; $display("FAIL rst_addr: got %h want 0", bus.data_memory_address); end
    n_cmp++; if (bus.data_memory_data_in !== 32'd0) begin n_fail++; $display("FAIL rst_data_in: got %h want 0", bus.data_memory_data_in); end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b want 1", bus.req_ready); end
  endtask

  task automatic test_load;
    preload(12'd123, 32'h1234_CDEF);
    do_op(1'b0, 3'b010, 32'h1EC, 32'd0, lat, nld, nst, ldc, stc, ma, din, rdata, err, rdy, brdy);
    n_cmp++; if (ldc !== 1) begin n_fail++; $display("FAIL lw_load_cycle: got %0d want 1", ldc); end
    n_cmp++; if (lat !== 3) begin n_fail++; $display("FAIL lw_latency: got %0d want 3", lat); end
    n_cmp++; if (ma !== 12'd123) begin n_fail++; $display("FAIL lw_mem_addr: got %0d want 123", ma); end
    n_cmp++; if (rdata !== 32'h1234_CDEF) begin n_fail++; $display("FAIL lw_rdata: got %h want 1234cdef", rdata); end
    n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL lw_err: got %b want 0", err); end
    n_cmp++; if ({nld, nst} !== {32'd1, 32'd0}) begin n_fail++; $display("FAIL lw_strobe_count: got %0d/%0d want 1/0", nld, nst); end
    n_cmp++; if (brdy !== 1'b0) begin n_fail++; $display("FAIL lw_busy_ready: got %b want 0", brdy); end
    @(negedge clk);
    n_cmp++; if ({bus.resp_valid, bus.resp_rdata} !== {1'b0, 32'h1234_CDEF}) begin n_fail++; $display("FAIL lw_hold: got %b/%h want 0/1234cdef", bus.resp_valid, bus.resp_rdata); end
    do_op(1'b0, 3'b000, 32'h1EF, 32'd0, lat, nld, nst, ldc, stc, ma, din, rdata, err, rdy, brdy);
    n_cmp++; if (rdata !== 32'h0000_0012) begin n_fail++; $display("FAIL lb_1ef: got %h want 00000012", rdata); end
    do_op(1'b0, 3'b001, 32'h1EC, 32'd0, lat, nld, nst, ldc, stc, ma, din, rdata, err, rdy, brdy);
    n_cmp++; if (rdata !== 32'hFFFF_CDEF) begin n_fail++; $display("FAIL lh_1ec: got %h want ffffcdef", rdata); end
    do_op(1'b0, 3'b101, 32'h1EC, 32'd0, lat, nld, nst, ldc, stc, ma, din, rdata, err, rdy, brdy);
    n_cmp++; if (rdata !== 32'h0000_CDEF) begin n_fail++; $display("FAIL lhu_1ec: got %h want 0000cdef", rdata); end
    do_op(1'b0, 3'b000, 32'h1ED, 32'd0, lat, nld, nst, ldc, stc, ma, din, rdata, err, rdy, brdy);
    n_cmp++; if (rdata !== 32'hFFFF_FFCD) begin n_fail++; $display("FAIL lb_1ed: got %h want ffffffcd", rdata); end
    do_op(1'b0, 3'b100, 32'h1EE, 32'd0, lat, nld, nst, ldc, stc, ma, din, rdata, err, rdy, brdy);
    n_cmp++; if (rdata !== 32'h0000_0034) begin n_fail++; $display("FAIL lbu_1ee: got %h want 00000034", rdata); end
    do_op(1'b0, 3'b001, 32'h1EE, 32'd0, lat, nld, nst, ldc, stc, ma, din, rdata, err, rdy, brdy);
    n_cmp++; if (rdata !== 32'h0000_1234) begin n_fail++; $display("FAIL lh_1ee: got %h want 00001234", rdata); end
  endtask

  task automatic test_store;
    do_op(1'b1, 3'b010, 32'h3FFC, 32'hFFFF_FFFF, lat, nld, nst, ldc, stc, ma, din, rdata, err, rdy, brdy);
    n_cmp++; if (stc !== 1) begin n_fail++; $display("FAIL sw_store_cycle: got %0d want 1", stc); end
    n_cmp++; if (ma !== 12'hFFF) begin n_fail++; $display("FAIL sw_mem_addr: got %h want fff", ma); end
    n_cmp++; if (lat !== 2) begin n_fail++; $display("FAIL sw_latency: got %0d want 2", lat); end
    n_cmp++; if ({nld, nst} !== {32'd0, 32'd1}) begin n_fail++; $display("FAIL sw_strobe_count: got %0d/%0d want 0/1", nld, nst); end
    n_cmp++; if ({err, rdata} !== {1'b0, 32'd0}) begin n_fail++; $display("FAIL sw_resp: got %b/%h want 0/0", err, rdata); end
    n_cmp++; if (mem[12'hFFF] !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL sw_ram_fff: got %h want ffffffff", mem[12'hFFF]); end
    do_op(1'b1, 3'b010, 32'h4000, 32'h5A5A_0001, lat, nld, nst, ldc, stc, ma, din, rdata, err, rdy, brdy);
    n_cmp++; if (ma !== 12'd0) begin n_fail++; $display("FAIL sw_wrap_addr: got %h want 000", ma); end
    n_cmp++; if (din !== 32'h5A5A_0001) begin n_fail++; $display("FAIL sw_wrap_din: got %h want 5a5a0001", din); end
    do_op(1'b0, 3'b010, 32'h0000_4000, 32'd0, lat, nld, nst, ldc, stc, ma, din, rdata, err, rdy, brdy);
    n_cmp++; if (rdata !== 32'h5A5A_0001) begin n_fail++; $display("FAIL lw_wrap_rdata: got %h want 5a5a0001", rdata); end
  endtask

  task automatic test_errors;
    preload(12'd123, 32'h1234_CDEF);
    do_op(1'b0, 3'b010, 32'h1EE, 32'd0, lat, nld, nst, ldc, stc, ma, din, rdata, err, rdy, brdy);
    n_cmp++; if ({lat, err} !== {32'd1, 1'b1}) begin n_fail++; $display("FAIL lw_misalign: got lat %0d err %b want 1/1", lat, err); end
    n_cmp++; if (nld + nst !== 0) begin n_fail++; $display("FAIL lw_misalign_strobes: got %0d want 0", nld + nst); end
    n_cmp++; if (rdata !== 32'd0) begin n_fail++; $display("FAIL lw_misalign_rdata: got %h want 0", rdata); end
    do_op(1'b1, 3'b001, 32'h1ED, 32'hFFFF_FFFF, lat, nld, nst, ldc, stc, ma, din, rdata, err, rdy, brdy);
    n_cmp++; if ({lat, err} !== {32'd1, 1'b1}) begin n_fail++; $display("FAIL sh_misalign: got lat %0d err %b want 1/1", lat, err); end
    n_cmp++; if (nld + nst !== 0) begin n_fail++; $display("FAIL sh_misalign_strobes: got %0d want 0", nld + nst); end
    do_op(1'b0, 3'b011, 32'h1EC, 32'd0, lat, nld, nst, ldc, stc, ma, din, rdata, err, rdy, brdy);
    n_cmp++; if ({lat, err, nld} !== {32'd1, 1'b1, 32'd0}) begin n_fail++; $display("FAIL load_f3_011: got lat %0d err %b loads %0d want 1/1/0", lat, err, nld); end
    do_op(1'b1, 3'b100, 32'h1EC, 32'd0, lat, nld, nst, ldc, stc, ma, din, rdata, err, rdy, brdy);
    n_cmp++; if ({lat, err, nst} !== {32'd1, 1'b1, 32'd0}) begin n_fail++; $display("FAIL store_f3_100: got lat %0d err %b stores %0d want 1/1/0", lat, err, nst); end
    n_cmp++; if (mem[123] !== 32'h1234_CDEF) begin n_fail++; $display("FAIL err_ram_intact: got %h want 1234cdef", mem[123]); end
  endtask

  task automatic test_rmw;
    preload(12'd123, 32'h1234_CDEF);
    do_op(1'b1, 3'b000, 32'h1ED, 32'hFFFF_FFAA, lat, nld, nst, ldc, stc, ma, din, rdata, err, rdy, brdy);
`ifdef LSU_RMW_EN
    n_cmp++; if ({nld, nst} !== {32'd1, 32'd1}) begin n_fail++; $display("FAIL sb_strobe_count: got %0d/%0d want 1/1", nld, nst); end
    n_cmp++; if ({ldc, stc} !== {32'd1, 32'd3}) begin n_fail++; $display("FAIL sb_strobe_cycles: got %0d/%0d want 1/3", ldc, stc); end
    n_cmp++; if ({lat, err} !== {32'd4, 1'b0}) begin n_fail++; $display("FAIL sb_resp: got lat %0d err %b want 4/0", lat, err); end
    n_cmp++; if (mem[123] !== 32'h1234_AAEF) begin n_fail++; $display("FAIL sb_ram: got %h want 1234aaef", mem[123]); end
    do_op(1'b1, 3'b001, 32'h1EE, 32'h1111_BEEF, lat, nld, nst, ldc, stc, ma, din, rdata, err, rdy, brdy);
    n_cmp++; if (mem[123] !== 32'hBEEF_AAEF) begin n_fail++; $display("FAIL sh_ram: got %h want beefaaef", mem[123]); end
    n_cmp++; if (lat !== 4) begin n_fail++; $display("FAIL sh_latency: got %0d want 4", lat); end
`else
    n_cmp++; if ({lat, err} !== {32'd1, 1'b1}) begin n_fail++; $display("FAIL sb_disabled: got lat %0d err %b want 1/1", lat, err); end
    n_cmp++; if (nld + nst !== 0) begin n_fail++; $display("FAIL sb_disabled_strobes: got %0d want 0", nld + nst); end
    n_cmp++; if (mem[123] !== 32'h1234_CDEF) begin n_fail++; $display("FAIL sb_disabled_ram: got %h want 1234cdef", mem[123]); end
`endif
  endtask

  task automatic test_back_to_back;
    preload(12'd123, 32'h1234_CDEF);
    do_op(1'b0, 3'b010, 32'h1EC, 32'd0, lat, nld, nst, ldc, stc, ma, din, rdata, err, rdy, brdy);
    do_op(1'b0, 3'b100, 32'h1EF, 32'd0, lat, nld, nst, ldc, stc, ma, din, rdata, err, rdy, brdy);
    n_cmp++; if (rdy !== 1'b1) begin n_fail++; $display("FAIL b2b_ready: got %b want 1", rdy); end
    n_cmp++; if ({lat, rdata} !== {32'd3, 32'h0000_0012}) begin n_fail++; $display("FAIL b2b_second: got lat %0d rdata %h want 3/00000012", lat, rdata); end
  endtask

  task automatic test_reset_midop;
    bit seen;
    preload(12'd123, 32'h1234_CDEF);
    seen = 1'b0;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = 32'h1EC;
`ifdef LSU_RMW_EN
    bus.req_funct3 = 3'b000; bus.req_wdata = 32'h0000_0077;
`else
    bus.req_funct3 = 3'b010; bus.req_wdata = 32'hDEAD_BEEF;
`endif
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (bus.store) begin seen = 1'b1; break; end
    end
    n_cmp++; if (seen !== 1'b1) begin n_fail++; $display("FAIL rstmid_store_seen: got %b want 1", seen); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.store !== 1'b0) begin n_fail++; $display("FAIL rstmid_store_async: got %b want 0", bus.store); end
    @(negedge clk);
    n_cmp++; if (mem[123] !== 32'h1234_CDEF) begin n_fail++; $display("FAIL rstmid_ram: got %h want 1234cdef", mem[123]); end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready: got %b want 1", bus.req_ready); end
    do_op(1'b0, 3'b010, 32'h1EC, 32'd0, lat, nld, nst, ldc, stc, ma, din, rdata, err, rdy, brdy);
    n_cmp++; if ({lat, rdata} !== {32'd3, 32'h1234_CDEF}) begin n_fail++; $display("FAIL rstmid_resume: got lat %0d rdata %h want 3/1234cdef", lat, rdata); end
  endtask

  initial begin
    test_reset();
    test_load();
    test_store();
    test_errors();
    test_rmw();
    test_back_to_back();
    test_reset_midop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
